// File: rtl/llc_output_encoder.sv
// LLC output encoder: buffers outgoing response, forward, memory request and
// DMA response messages in per-channel FIFOs and drains them to the LLC
// output interfaces. DMA responses leave as word beats of a cache line.
//
// Handshake contract (all output channels): a beat transfers on a rising
// edge where valid and ready are both 1. Once valid is raised, valid and all
// payload fields hold until that transfer happens. valid never depends on
// ready.

// Small synchronous FIFO. full/empty come from registered occupancy only, so
// a push into a full FIFO is dropped even when a pop happens on the same edge.
module llc_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign ovf     = push && full;
  // Head is masked while empty so idle outputs read as zero.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

module llc_output_encoder #(
  parameter int DEPTH     = 2,
  parameter int RSP_W     = 160,
  parameter int FWD_W     = 40,
  parameter int MEM_W     = 170,
  parameter int DMA_HDR_W = 40,
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 32,
  parameter int BEATS     = LINE_W / WORD_W,
  parameter int WCNT_W    = $clog2(BEATS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rsp_push,
  input  logic [RSP_W-1:0]     rsp_data,
  output logic                 rsp_full,
  input  logic                 fwd_push,
  input  logic [FWD_W-1:0]     fwd_data,
  output logic                 fwd_full,
  input  logic                 mem_push,
  input  logic [MEM_W-1:0]     mem_data,
  output logic                 mem_full,
  input  logic                 dma_push,
  input  logic [DMA_HDR_W-1:0] dma_hdr,
  input  logic [LINE_W-1:0]    dma_line,
  input  logic [WCNT_W-1:0]    dma_words,
  output logic                 dma_full,
  output logic                 llc_rsp_out_valid,
  input  logic                 llc_rsp_out_ready,
  output logic [RSP_W-1:0]     llc_rsp_out_data,
  output logic                 llc_fwd_out_valid,
  input  logic                 llc_fwd_out_ready,
  output logic [FWD_W-1:0]     llc_fwd_out_data,
  output logic                 llc_mem_req_valid,
  input  logic                 llc_mem_req_ready,
  output logic [MEM_W-1:0]     llc_mem_req_data,
  output logic                 llc_dma_rsp_out_valid,
  input  logic                 llc_dma_rsp_out_ready,
  output logic [DMA_HDR_W-1:0] llc_dma_rsp_out_hdr,
  output logic [WORD_W-1:0]    llc_dma_rsp_out_word,
  output logic                 llc_dma_rsp_out_last,
  output logic                 out_idle,
  output logic                 overflow_err
);
  localparam int E_W = DMA_HDR_W + LINE_W + WCNT_W;
  localparam logic [WCNT_W-1:0] BEATS_C = WCNT_W'(BEATS);

  typedef enum logic {DMA_IDLE = 1'b0, DMA_SEND = 1'b1} dma_state_t;

  // Exposed by name so checkers can bind to the serializer state.
  dma_state_t dma_state;
  dma_state_t dma_state_nx;

  logic rsp_empty, fwd_empty, mem_empty, dma_empty;
  logic rsp_ovf, fwd_ovf, mem_ovf, dma_ovf;

  logic [E_W-1:0]       dma_head;
  logic [DMA_HDR_W-1:0] head_hdr;
  logic [LINE_W-1:0]    head_line;
  logic [WCNT_W-1:0]    head_words;
  logic [WCNT_W-1:0]    head_nwords;

  logic [DMA_HDR_W-1:0] hdr_q;
  logic [LINE_W-1:0]    line_q;
  logic [WCNT_W-1:0]    nwords_q;
  logic [WCNT_W-1:0]    beat_cnt;
  logic                 beat_last;
  logic                 dma_load;

  llc_out_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .din(rsp_data),
    .pop(llc_rsp_out_ready), .dout(llc_rsp_out_data),
    .empty(rsp_empty), .full(rsp_full), .ovf(rsp_ovf)
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W(FWD_W)) u_fwd_fifo (
    .clk(clk), .rst(rst), .push(fwd_push), .din(fwd_data),
    .pop(llc_fwd_out_ready), .dout(llc_fwd_out_data),
    .empty(fwd_empty), .full(fwd_full), .ovf(fwd_ovf)
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W(MEM_W)) u_mem_fifo (
    .clk(clk), .rst(rst), .push(mem_push), .din(mem_data),
    .pop(llc_mem_req_ready), .dout(llc_mem_req_data),
    .empty(mem_empty), .full(mem_full), .ovf(mem_ovf)
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W(E_W)) u_dma_fifo (
    .clk(clk), .rst(rst), .push(dma_push), .din({dma_hdr, dma_line, dma_words}),
    .pop(dma_load), .dout(dma_head),
    .empty(dma_empty), .full(dma_full), .ovf(dma_ovf)
  );

  assign llc_rsp_out_valid = !rsp_empty;
  assign llc_fwd_out_valid = !fwd_empty;
  assign llc_mem_req_valid = !mem_empty;

  assign {head_hdr, head_line, head_words} = dma_head;
  // Zero or oversize word counts mean a full line.
  assign head_nwords = (head_words == '0 || head_words > BEATS_C) ? BEATS_C : head_words;
  assign beat_last   = (beat_cnt == nwords_q - 1'b1);
  // Load from IDLE, or back-to-back on the final accepted beat so no bubble appears.
  assign dma_load    = !dma_empty &&
                       (dma_state == DMA_IDLE ||
                        (llc_dma_rsp_out_ready && beat_last));

  assign out_idle = rsp_empty && fwd_empty && mem_empty && dma_empty &&
                    (dma_state == DMA_IDLE);

  // Sticky overflow flag: any dropped push on any channel.
  always_ff @(posedge clk) begin
    if (!rst) overflow_err <= 1'b0;
    else if (rsp_ovf || fwd_ovf || mem_ovf || dma_ovf) overflow_err <= 1'b1;
  end

  // DMA serializer state register.
  always_ff @(posedge clk) begin
    if (!rst) dma_state <= DMA_IDLE;
    else      dma_state <= dma_state_nx;
  end

  // DMA serializer next state: leave SEND only when the last beat drains an empty FIFO.
  always_comb begin
    dma_state_nx = dma_state;
    case (dma_state)
      DMA_IDLE: if (!dma_empty) dma_state_nx = DMA_SEND;
      DMA_SEND: if (llc_dma_rsp_out_ready && beat_last && dma_empty) dma_state_nx = DMA_IDLE;
      default:  dma_state_nx = DMA_IDLE;
    endcase
  end

  // DMA line/header capture and beat counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_q    <= '0;
      line_q   <= '0;
      nwords_q <= '0;
      beat_cnt <= '0;
    end else if (dma_load) begin
      hdr_q    <= head_hdr;
      line_q   <= head_line;
      nwords_q <= head_nwords;
      beat_cnt <= '0;
    end else if (dma_state == DMA_SEND && llc_dma_rsp_out_ready && !beat_last) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // DMA outputs: driven only while sending, zero otherwise.
  always_comb begin
    llc_dma_rsp_out_valid = 1'b0;
    llc_dma_rsp_out_hdr   = '0;
    llc_dma_rsp_out_word  = '0;
    llc_dma_rsp_out_last  = 1'b0;
    if (dma_state == DMA_SEND) begin
      llc_dma_rsp_out_valid = 1'b1;
      llc_dma_rsp_out_hdr   = hdr_q;
      llc_dma_rsp_out_last  = beat_last;
      for (int i = 0; i < BEATS; i++) begin
        if (beat_cnt == WCNT_W'(i)) llc_dma_rsp_out_word = line_q[i*WORD_W +: WORD_W];
      end
    end
  end
endmodule

// File: doc/llc_output_encoder.md
Name: llc_output_encoder

Overview:
- Output-side counterpart of the LLC input decoder. It accepts outgoing messages from the LLC process stage and buffers them per channel: response, forward, memory request and DMA response.
- Each channel is drained to the LLC output interfaces under a valid/ready handshake.
- DMA responses are serialized from a full cache line into word beats.
- Reports backpressure (per-channel full) and aggregate idle to the process stage, for flush and reset completion.

Parameters:
- DEPTH, 2, entries per channel FIFO (power of 2, ≥1).
- RSP_W, 160, response payload width.
- FWD_W, 40, forward payload width.
- MEM_W, 170, memory request payload width.
- DMA_HDR_W, 40, DMA response header width.
- LINE_W, 128, cache line width.
- WORD_W, 32, DMA beat width. BEATS = LINE_W/WORD_W (derived, 4).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- rsp_push  in  1  process stage enqueues response
- rsp_data  in  RSP_W  response payload
- rsp_full  out  1  response FIFO full
- fwd_push / fwd_data / fwd_full  in/in/out  1/FWD_W/1  same, forward channel
- mem_push / mem_data / mem_full  in/in/out  1/MEM_W/1  same, memory request channel
- dma_push  in  1  enqueue DMA response
- dma_hdr  in  DMA_HDR_W  DMA header
- dma_line  in  LINE_W  line data
- dma_words  in  clog2(BEATS)+1  number of words to send
- dma_full  out  1  DMA FIFO full
- llc_rsp_out_valid / llc_rsp_out_ready / llc_rsp_out_data  out/in/out  1/1/RSP_W  response output
- llc_fwd_out_valid / llc_fwd_out_ready / llc_fwd_out_data  out/in/out  1/1/FWD_W  forward output
- llc_mem_req_valid / llc_mem_req_ready / llc_mem_req_data  out/in/out  1/1/MEM_W  memory request output
- llc_dma_rsp_out_valid / llc_dma_rsp_out_ready  out/in  1/1  DMA response handshake
- llc_dma_rsp_out_hdr  out  DMA_HDR_W  header, constant across beats of one response
- llc_dma_rsp_out_word  out  WORD_W  current beat
- llc_dma_rsp_out_last  out  1  final beat of the response
- out_idle  out  1  all FIFOs empty and DMA FSM in IDLE
- overflow_err  out  1  sticky: push received while full

Behaviour:
- Reset (rst=0 at posedge): all FIFOs emptied; DMA FSM goes to IDLE with beat_cnt=0.
  - All valid outputs 0; data, hdr, word and last outputs 0; full outputs 0; overflow_err 0; out_idle 1.
  - Reset mid-transfer abandons the partial DMA response; no further beats are sent.
- FIFOs (rsp, fwd, mem, dma):
  - x_full is derived from registered occupancy only, i.e. the pre-pop count equals DEPTH.
  - A push while x_full is dropped and sets overflow_err, which stays set until reset.
  - This holds even if a pop occurs in the same cycle.
  - Push and pop on the same cycle with occupancy < DEPTH: count unchanged, order preserved.
- rsp/fwd/mem outputs:
  - x_valid = FIFO non-empty; x_data = head entry.
  - Pop on valid & ready.
  - A push in cycle N is visible as valid in cycle N+1.
  - valid and data stay stable until accepted.
  - Channels are independent; there is no cross-channel ordering or arbitration.
- DMA serializer FSM:
  - IDLE → SEND when the DMA FIFO is non-empty. On that edge: pop the head into the line register and latch hdr, set beat_cnt=0, and latch nwords = (dma_words==0 || dma_words>BEATS) ? BEATS : dma_words.
  - SEND outputs:
    - valid=1
    - word = line[beat_cnt*WORD_W +: WORD_W]
    - last = (beat_cnt == nwords-1)
  - SEND, valid & ready & !last: beat_cnt+1.
  - SEND, valid & ready & last, FIFO non-empty: load the next entry on the same edge and stay in SEND (no bubble).
  - SEND, valid & ready & last, FIFO empty: go to IDLE, valid=0.
  - Latency: a push in cycle N gives the first beat valid in cycle N+2.
  - Without ready, all DMA outputs hold.
- out_idle is combinational from registered state: 1 iff all four FIFOs are empty and the FSM is in IDLE. It goes low the cycle after any accepted push.

Test Plan:
- Reset, then rsp_push with data 0xA5 in cycle 0 and ready held 1 → llc_rsp_out_valid=1 with data 0xA5 in cycle 1 only; out_idle returns to 1 in cycle 2.
- mem_push ×3 back-to-back with DEPTH=2 and ready=0 → mem_full=1 after 2 pushes; the 3rd push is dropped and overflow_err=1. Then ready=1 → exactly 2 beats, in order.
- dma_push with line 0x44443333_22221111_00000000_DEADBEEF (word0 = low-order word), words=4, ready=1 → beats DEADBEEF, 00000000, 22221111, 44443333 in cycles 2–5; last=1 only in cycle 5; hdr constant throughout.
- DMA entries with dma_words=2 and then dma_words=0 queued → 2 beats then 4 beats; no idle cycle between the first response's last beat and the second response's first beat.
- DMA ready toggling 1,0,0,1,… → each beat held stable while ready=0; beat_cnt advances only on handshake.
- Reset asserted after beat 1 of a 4-beat transfer with a second entry queued → next cycle valid=0 and out_idle=1; no beats emitted afterwards.
